// File: rtl/mod_updown_cnt_if.sv
// mod_updown_cnt_if: control/status bundle for mod_updown_cnt; WRAP_CNT exists only with MODCNT_WRAP_CNT_EN
interface mod_updown_cnt_if #(
   parameter int WIDTH = 3
`ifdef MODCNT_WRAP_CNT_EN
   , parameter int WRAP_CNT_WIDTH = 8
`endif
);
   logic             CLEAR;
   logic             LOAD;
   logic [WIDTH-1:0] LOAD_VAL;
   logic             UP_EN;
   logic             DOWN_EN;
   logic [WIDTH-1:0] STEP;
   logic             ONESHOT;
   logic [WIDTH-1:0] CNT;
   logic             TC;
   logic             WRAP;
   logic             ERR;
   logic             HALTED;
`ifdef MODCNT_WRAP_CNT_EN
   logic [WRAP_CNT_WIDTH-1:0] WRAP_CNT;
`endif
   modport master (
      output CLEAR, LOAD, LOAD_VAL, UP_EN, DOWN_EN, STEP, ONESHOT,
      input  CNT, TC, WRAP, ERR, HALTED
`ifdef MODCNT_WRAP_CNT_EN
      , input WRAP_CNT
`endif
   );
   modport slave (
      input  CLEAR, LOAD, LOAD_VAL, UP_EN, DOWN_EN, STEP, ONESHOT,
      output CNT, TC, WRAP, ERR, HALTED
`ifdef MODCNT_WRAP_CNT_EN
      , output WRAP_CNT
`endif
   );
endinterface

// File: rtl/mod_updown_cnt.sv
// mod_updown_cnt: modulo up/down counter with step, load, one-shot halt and wrap pulse; MODCNT_WRAP_CNT_EN adds a saturating wrap tally
module mod_updown_cnt #(
   parameter int WIDTH  = 3,
   parameter int MODULO = 7
`ifdef MODCNT_WRAP_CNT_EN
   , parameter int WRAP_CNT_WIDTH = 8
`endif
) (
   input logic             CLK,
   input logic             RSTN,
   mod_updown_cnt_if.slave bus
);
   localparam logic [WIDTH:0]   mod_v = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] top_v = WIDTH'(MODULO-1);
   typedef enum logic {RUN, HALT} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d, err_q, err_d;
   logic [WIDTH:0]   s_up, s_dn;
   logic             up_wrap, dn_wrap;
   // next count, state and pulses: clear beats load beats counting
   always_comb begin
      s_up    = {1'b0, cnt_q} + {1'b0, bus.STEP};
      s_dn    = {1'b0, cnt_q} - {1'b0, bus.STEP};
      up_wrap = s_up >= mod_v;
      dn_wrap = cnt_q < bus.STEP;
      cnt_d   = cnt_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (bus.CLEAR) begin
         cnt_d   = '0;
         state_d = RUN;
      end else if (bus.LOAD) begin
         state_d = RUN;
         err_d   = {1'b0, bus.LOAD_VAL} >= mod_v;
         cnt_d   = err_d ? top_v : bus.LOAD_VAL;
      end else if (state_q == RUN && (bus.UP_EN ^ bus.DOWN_EN) && bus.STEP != '0) begin
         if ({1'b0, bus.STEP} >= mod_v) begin
            err_d = 1'b1;
         end else begin
            wrap_d  = bus.UP_EN ? up_wrap : dn_wrap;
            cnt_d   = WIDTH'(bus.UP_EN ? (up_wrap ? s_up - mod_v : s_up)
                                       : (dn_wrap ? s_dn + mod_v : s_dn));
            state_d = (wrap_d && bus.ONESHOT) ? HALT : RUN;
         end
      end
   end
   // state, count and one-cycle pulse registers
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= RUN;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end
   assign bus.CNT    = cnt_q;
   assign bus.TC     = cnt_q == top_v;
   assign bus.WRAP   = wrap_q;
   assign bus.ERR    = err_q;
   assign bus.HALTED = state_q == HALT;
`ifdef MODCNT_WRAP_CNT_EN
   logic [WRAP_CNT_WIDTH-1:0] wc_q;
   // wrap tally: saturates at all-ones, cleared by CLEAR but kept across LOAD
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) wc_q <= '0;
      else if (bus.CLEAR) wc_q <= '0;
      else if (wrap_d && !(&wc_q)) wc_q <= wc_q + 1'b1;
   end
   assign bus.WRAP_CNT = wc_q;
`endif
endmodule

// File: tb/tb_mod_updown_cnt.sv
// tb_mod_updown_cnt: scoreboard bench for mod_updown_cnt (WIDTH=3, MODULO=7)
module tb_mod_updown_cnt;
   localparam int W = 3;
   localparam int M = 7;
`ifdef MODCNT_WRAP_CNT_EN
   localparam int WCW = 2;
`endif
   typedef struct {
      int cnt;
      int tc;
      int wrap;
      int err;
      int halted;
      int wc;
   } exp_t;
   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_cnt = 0;
   int   m_halt = 0;
   int   m_wc = 0;
   always #5 CLK = ~CLK;
`ifdef MODCNT_WRAP_CNT_EN
   mod_updown_cnt_if #(.WIDTH(W), .WRAP_CNT_WIDTH(WCW)) bus ();
   mod_updown_cnt #(.WIDTH(W), .MODULO(M), .WRAP_CNT_WIDTH(WCW)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
`else
   mod_updown_cnt_if #(.WIDTH(W)) bus ();
   mod_updown_cnt #(.WIDTH(W), .MODULO(M)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
`endif
   task automatic check(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic cyc(input bit cl, input bit ld, input int lv, input bit up, input bit dn, input int st, input bit os);
      exp_t e;
      int   n;
      int   wr;
      int   er;
      bus.CLEAR    = cl;
      bus.LOAD     = ld;
      bus.LOAD_VAL = W'(lv);
      bus.UP_EN    = up;
      bus.DOWN_EN  = dn;
      bus.STEP     = W'(st);
      bus.ONESHOT  = os;
      wr = 0;
      er = 0;
      if (cl) begin
         m_cnt  = 0;
         m_halt = 0;
         m_wc   = 0;
      end else if (ld) begin
         m_halt = 0;
         if (lv < M) m_cnt = lv;
         else begin
            m_cnt = M - 1;
            er    = 1;
         end
      end else if (m_halt == 0 && up != dn && st != 0) begin
         if (st >= M) er = 1;
         else begin
            n     = up ? m_cnt + st : m_cnt - st;
            wr    = (n < 0 || n >= M) ? 1 : 0;
            m_cnt = (n + M) % M;
            if (wr == 1 && os) m_halt = 1;
         end
      end
`ifdef MODCNT_WRAP_CNT_EN
      if (wr == 1 && m_wc < (1 << WCW) - 1) m_wc++;
`endif
      e.cnt    = m_cnt;
      e.tc     = (m_cnt == M - 1) ? 1 : 0;
      e.wrap   = wr;
      e.err    = er;
      e.halted = m_halt;
      e.wc     = m_wc;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check("cnt", int'(bus.CNT), e.cnt);
      check("tc", int'(bus.TC), e.tc);
      check("wrap", int'(bus.WRAP), e.wrap);
      check("err", int'(bus.ERR), e.err);
      check("halted", int'(bus.HALTED), e.halted);
`ifdef MODCNT_WRAP_CNT_EN
      check("wrap_cnt", int'(bus.WRAP_CNT), e.wc);
`endif
   endtask
   initial begin
      bus.CLEAR    = 1'b0;
      bus.LOAD     = 1'b0;
      bus.LOAD_VAL = '0;
      bus.UP_EN    = 1'b0;
      bus.DOWN_EN  = 1'b0;
      bus.STEP     = '0;
      bus.ONESHOT  = 1'b0;
      #12;
      check("rst_cnt", int'(bus.CNT), 0);
      check("rst_tc", int'(bus.TC), 0);
      check("rst_wrap", int'(bus.WRAP), 0);
      check("rst_err", int'(bus.ERR), 0);
      check("rst_halted", int'(bus.HALTED), 0);
      @(negedge CLK);
      RSTN = 1'b1;
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 1, 0);
      cyc(0, 1, 2, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 3, 0);
      cyc(0, 1, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 2, 1);
      cyc(0, 0, 0, 1, 0, 2, 1);
      cyc(0, 0, 0, 1, 0, 1, 0);
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(0, 1, 7, 0, 0, 0, 0);
      cyc(0, 1, 7, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 7, 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 1, 3, 1, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 6, 0, 0, 0, 0);
         cyc(0, 0, 0, 1, 0, 1, 0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 80; i++)
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 3) == 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 3, 1);
      #2;
      RSTN = 1'b0;
      #1;
      check("async_cnt", int'(bus.CNT), 0);
      check("async_halted", int'(bus.HALTED), 0);
      check("async_wrap", int'(bus.WRAP), 0);
      m_cnt  = 0;
      m_halt = 0;
      m_wc   = 0;
      #1;
      RSTN = 1'b1;
      cyc(0, 0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
